acumulador_quadrante_ov7670: RTL and testbench

ACUMULADOR_QUADRANTE_OV7670 -- requirements
Module: acumulador_quadrante_ov7670

---
 rtl/acumulador_quadrante_ov7670.sv | 135 +++++++++++++
 tb/tb_acumulador_quadrante_ov7670.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acumulador_quadrante_ov7670.sv
// rtl/acumulador_quadrante_ov7670.sv - per-quadrant RGB565 sum/count accumulator for an OV7670 byte stream
module acumulador_quadrante_ov7670 (
    input  logic        clock,
    input  logic        reset,
    input  logic        byte_estavel,
    input  logic [7:0]  dado,
    input  logic        zera_fase,
    input  logic        limpar,
    input  logic        fim_frame,
    input  logic [1:0]  linha_quadrante,
    input  logic [1:0]  coluna_quadrante,
    input  logic [3:0]  sel_quadrante,
    output logic        pixel_armazenado,
    output logic [23:0] soma_r,
    output logic [23:0] soma_g,
    output logic [23:0] soma_b,
    output logic [19:0] num_pixels,
    output logic        pronto,
    output logic [3:0]  db_estado
);

    typedef enum logic [3:0] {
        OCIOSO   = 4'b0000,
        ACUMULA  = 4'b0001,
        FINALIZA = 4'b0010,
        PRONTO   = 4'b0011
    } estado_t;

    estado_t          estado, proximo;
    logic             fase;
    logic [7:0]       byte0;
    logic             s1_valido;
    logic [4:0]       s1_r, s1_b;
    logic [5:0]       s1_g;
    logic [3:0]       s1_idx;
    logic [8:0][23:0] acc_r, acc_g, acc_b;
    logic [8:0][19:0] acc_n;
    logic             quadrante_ok;
    logic [3:0]       idx;

    function automatic logic [23:0] soma_sat(input logic [23:0] a, input logic [5:0] b);
        logic [24:0] s;
        s = {1'b0, a} + {19'd0, b};
        return s[24] ? 24'hFFFFFF : s[23:0];
    endfunction

    assign pixel_armazenado = byte_estavel & fase;
    assign quadrante_ok     = (linha_quadrante != 2'd3) && (coluna_quadrante != 2'd3);
    assign idx              = {2'b00, linha_quadrante} * 4'd3 + {2'b00, coluna_quadrante};
    assign pronto           = (estado == PRONTO);
    assign db_estado        = estado;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= OCIOSO;
        else        estado <= proximo;
    end

    always_comb begin
        proximo = estado;
        if (limpar) begin
            proximo = ACUMULA;
        end else begin
            case (estado)
                ACUMULA:  if (fim_frame) proximo = FINALIZA;
                FINALIZA: proximo = PRONTO;
                default:  proximo = estado;
            endcase
        end
    end

    // A line/frame restart beats a simultaneous byte strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fase  <= 1'b0;
            byte0 <= '0;
        end else if (zera_fase || limpar) begin
            fase <= 1'b0;
        end else if (byte_estavel) begin
            if (!fase) byte0 <= dado;
            fase <= ~fase;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valido <= 1'b0;
            s1_r      <= '0;
            s1_g      <= '0;
            s1_b      <= '0;
            s1_idx    <= '0;
        end else begin
            s1_valido <= pixel_armazenado && quadrante_ok && (estado == ACUMULA) && !limpar;
            if (pixel_armazenado) begin
                s1_r   <= byte0[7:3];
                s1_g   <= {byte0[2:0], dado[7:5]};
                s1_b   <= dado[4:0];
                s1_idx <= idx;
            end
        end
    end

    // Stage 2 commits in any state so a pixel captured with fim_frame lands during FINALIZA.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
            acc_n <= '0;
        end else if (limpar) begin
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
            acc_n <= '0;
        end else if (s1_valido && (s1_idx < 4'd9)) begin
            acc_r[s1_idx] <= soma_sat(acc_r[s1_idx], {1'b0, s1_r});
            acc_g[s1_idx] <= soma_sat(acc_g[s1_idx], s1_g);
            acc_b[s1_idx] <= soma_sat(acc_b[s1_idx], {1'b0, s1_b});
            if (acc_n[s1_idx] != 20'hFFFFF) acc_n[s1_idx] <= acc_n[s1_idx] + 20'd1;
        end
    end

    always_comb begin
        soma_r     = '0;
        soma_g     = '0;
        soma_b     = '0;
        num_pixels = '0;
        if (sel_quadrante < 4'd9) begin
            soma_r     = acc_r[sel_quadrante];
            soma_g     = acc_g[sel_quadrante];
            soma_b     = acc_b[sel_quadrante];
            num_pixels = acc_n[sel_quadrante];
        end
    end

endmodule

// File: tb/tb_acumulador_quadrante_ov7670.sv
// tb/tb_acumulador_quadrante_ov7670.sv - self-checking bench for acumulador_quadrante_ov7670
module tb_acumulador_quadrante_ov7670;

    logic        clock = 1'b0;
    logic        reset;
    logic        byte_estavel, zera_fase, limpar, fim_frame;
    logic [7:0]  dado;
    logic [1:0]  linha_quadrante, coluna_quadrante;
    logic [3:0]  sel_quadrante;
    logic        pixel_armazenado, pronto;
    logic [23:0] soma_r, soma_g, soma_b;
    logic [19:0] num_pixels;
    logic [3:0]  db_estado;

    logic [8:0][23:0] pre;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  b0, b1;
        logic [1:0]  l, c;
        int          er, eg, eb;
    } vec_t;
    vec_t tabela [5];

    int unsigned mr [9], mg [9], mb [9], mn [9];

    acumulador_quadrante_ov7670 dut (
        .clock(clock), .reset(reset), .byte_estavel(byte_estavel), .dado(dado),
        .zera_fase(zera_fase), .limpar(limpar), .fim_frame(fim_frame),
        .linha_quadrante(linha_quadrante), .coluna_quadrante(coluna_quadrante),
        .sel_quadrante(sel_quadrante), .pixel_armazenado(pixel_armazenado),
        .soma_r(soma_r), .soma_g(soma_g), .soma_b(soma_b), .num_pixels(num_pixels),
        .pronto(pronto), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nome, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b, input logic fim, output logic pa);
        byte_estavel = 1'b1;
        dado = b;
        fim_frame = fim;
        #1 pa = pixel_armazenado;
        cyc();
        byte_estavel = 1'b0;
        fim_frame = 1'b0;
    endtask

    task automatic pixel(input logic [15:0] p, input logic [1:0] l, input logic [1:0] c, input logic fim);
        logic pa;
        linha_quadrante = l;
        coluna_quadrante = c;
        strobe(p[15:8], 1'b0, pa);
        strobe(p[7:0], fim, pa);
    endtask

    task automatic do_limpar();
        limpar = 1'b1;
        cyc();
        limpar = 1'b0;
    endtask

    task automatic check_quad(input string tag, input int q, input int er, input int eg, input int eb, input int en);
        sel_quadrante = q[3:0];
        #1;
        check($sformatf("%s_r_q%0d", tag, q), soma_r, er);
        check($sformatf("%s_g_q%0d", tag, q), soma_g, eg);
        check($sformatf("%s_b_q%0d", tag, q), soma_b, eb);
        check($sformatf("%s_n_q%0d", tag, q), num_pixels, en);
    endtask

    initial begin
        logic pa;
        int q;
        logic [15:0] p;
        logic [1:0] l, c;

        tabela[0] = '{8'hF8, 8'h1F, 2'd0, 2'd0, 31, 0, 31};
        tabela[1] = '{8'h07, 8'hE0, 2'd1, 2'd2, 0, 63, 0};
        tabela[2] = '{8'hA5, 8'h5A, 2'd2, 2'd0, 20, 42, 26};
        tabela[3] = '{8'h12, 8'h34, 2'd0, 2'd1, 2, 17, 20};
        tabela[4] = '{8'hFF, 8'hFF, 2'd2, 2'd2, 31, 63, 31};

        reset = 1'b0;
        byte_estavel = 1'b1;
        dado = 8'h00; zera_fase = 1'b0; limpar = 1'b0; fim_frame = 1'b0;
        linha_quadrante = 2'd0; coluna_quadrante = 2'd0; sel_quadrante = 4'd0;
        repeat (2) cyc();
        check("reset_db", db_estado, 4'd0);
        check("reset_pronto", pronto, 1'b0);
        check("reset_pa", pixel_armazenado, 1'b0);
        check("reset_n", num_pixels, 0);
        byte_estavel = 1'b0;
        reset = 1'b1;
        cyc();
        check("ocioso_db", db_estado, 4'd0);

        // Single pixel per quadrant, table driven
        for (int i = 0; i < 5; i++) begin
            do_limpar();
            check($sformatf("t%0d_acumula", i), db_estado, 4'd1);
            linha_quadrante = tabela[i].l;
            coluna_quadrante = tabela[i].c;
            strobe(tabela[i].b0, 1'b0, pa);
            check($sformatf("t%0d_pa0", i), pa, 1'b0);
            strobe(tabela[i].b1, 1'b0, pa);
            check($sformatf("t%0d_pa1", i), pa, 1'b1);
            fim_frame = 1'b1;
            cyc();
            fim_frame = 1'b0;
            check($sformatf("t%0d_finaliza", i), db_estado, 4'd2);
            check($sformatf("t%0d_pronto_early", i), pronto, 1'b0);
            cyc();
            check($sformatf("t%0d_pronto", i), pronto, 1'b1);
            check($sformatf("t%0d_db", i), db_estado, 4'd3);
            q = int'(tabela[i].l) * 3 + int'(tabela[i].c);
            check_quad($sformatf("t%0d", i), q, tabela[i].er, tabela[i].eg, tabela[i].eb, 1);
        end

        // Four white pixels at (2,1), pulse pattern of pixel_armazenado
        do_limpar();
        linha_quadrante = 2'd2;
        coluna_quadrante = 2'd1;
        for (int i = 0; i < 8; i++) begin
            strobe(8'hFF, 1'b0, pa);
            check($sformatf("white_pa_%0d", i + 1), pa, (i % 2 == 1) ? 1'b1 : 1'b0);
        end
        cyc();
        for (int k = 0; k < 9; k++)
            if (k == 7) check_quad("white", k, 124, 252, 124, 4);
            else        check_quad("white", k, 0, 0, 0, 0);

        // zera_fase drops a dangling byte0
        do_limpar();
        linha_quadrante = 2'd1;
        coluna_quadrante = 2'd1;
        strobe(8'hAB, 1'b0, pa);
        zera_fase = 1'b1;
        cyc();
        zera_fase = 1'b0;
        strobe(8'h00, 1'b0, pa);
        check("zf_pa0", pa, 1'b0);
        strobe(8'h00, 1'b0, pa);
        check("zf_pa1", pa, 1'b1);
        cyc();
        check_quad("zf", 4, 0, 0, 0, 1);

        // fim_frame with byte1, then bytes in PRONTO ignored
        do_limpar();
        pixel(16'hF81F, 2'd1, 2'd0, 1'b1);
        check("coinc_finaliza", db_estado, 4'd2);
        cyc();
        check("coinc_pronto", pronto, 1'b1);
        check_quad("coinc", 3, 31, 0, 31, 1);
        pixel(16'hFFFF, 2'd1, 2'd0, 1'b0);
        pixel(16'hFFFF, 2'd1, 2'd0, 1'b0);
        cyc(); cyc();
        check_quad("pronto_drop", 3, 31, 0, 31, 1);
        check("pronto_hold", pronto, 1'b1);
        check_quad("sel9", 9, 0, 0, 0, 0);

        // Saturation from a preloaded red sum
        do_limpar();
        pre = '0;
        pre[0] = 24'hFFFF00;
        force dut.acc_r = pre;
        #1;
        release dut.acc_r;
        for (int i = 0; i < 10; i++) pixel(16'hF800, 2'd0, 2'd0, 1'b0);
        cyc(); cyc();
        check_quad("sat", 0, 24'hFFFFFF, 0, 0, 10);
        do_limpar();
        check("sat_clr_db", db_estado, 4'd1);
        for (int k = 0; k < 9; k++) check_quad("sat_clr", k, 0, 0, 0, 0);

        // Asynchronous reset during ACUMULA
        do_limpar();
        pixel(16'hFFFF, 2'd1, 2'd1, 1'b0);
        pixel(16'hFFFF, 2'd1, 2'd1, 1'b0);
        cyc(); cyc();
        check_quad("pre_rst", 4, 62, 126, 62, 2);
        strobe(8'hFF, 1'b0, pa);
        byte_estavel = 1'b1;
        #1 check("pre_rst_pa", pixel_armazenado, 1'b1);
        #1 reset = 1'b0;
        #1;
        check("rst_pa", pixel_armazenado, 1'b0);
        check("rst_db", db_estado, 4'd0);
        check("rst_pronto", pronto, 1'b0);
        check_quad("rst", 4, 0, 0, 0, 0);
        byte_estavel = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        pixel(16'hFFFF, 2'd1, 2'd1, 1'b0);
        fim_frame = 1'b1;
        cyc();
        fim_frame = 1'b0;
        cyc(); cyc();
        check("ocioso_pronto", pronto, 1'b0);
        check("ocioso_state", db_estado, 4'd0);
        check_quad("ocioso_drop", 4, 0, 0, 0, 0);

        // Random frame against a plain-arithmetic model
        for (int k = 0; k < 9; k++) begin mr[k] = 0; mg[k] = 0; mb[k] = 0; mn[k] = 0; end
        do_limpar();
        for (int i = 0; i < 300; i++) begin
            p = 16'($urandom);
            l = 2'($urandom_range(0, 3));
            c = 2'($urandom_range(0, 3));
            pixel(p, l, c, 1'b0);
            if (l != 2'd3 && c != 2'd3) begin
                q = int'(l) * 3 + int'(c);
                mr[q] += p[15:11];
                mg[q] += p[10:5];
                mb[q] += p[4:0];
                mn[q] += 1;
            end
            if ($urandom_range(0, 3) == 0) cyc();
        end
        fim_frame = 1'b1;
        cyc();
        fim_frame = 1'b0;
        cyc();
        check("rand_pronto", pronto, 1'b1);
        for (int k = 0; k < 16; k++)
            if (k < 9) check_quad("rand", k, mr[k], mg[k], mb[k], mn[k]);
            else       check_quad("rand", k, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
